// File: rtl/handshake_src_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : handshake_src_ctrl
//  Purpose  : Source-side controller for a req/ack clock-domain handshake.
//             Upstream words are buffered in a small FIFO. Each word is
//             launched to the synchronizer (din + one-cycle sready pulse)
//             only while the synchronizer reports idle. The controller then
//             waits for the synchronizer to go busy and return to idle
//             before it counts the transfer as complete.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    sclk      in   source-domain clock
//    rst_n     in   asynchronous active-low reset
//    in_valid  in   upstream word offered
//    in_data   in   upstream word [WIDTH]
//    in_ready  out  FIFO not full (combinational)
//    sidle     in   synchronizer idle (sreq=0 and sack=0)
//    sready    out  registered one-cycle launch pulse
//    din       out  registered word presented to the synchronizer [WIDTH]
//    busy      out  FSM not idle or FIFO not empty
//    tx_count  out  completed transfers, wraps at 16 bits
//    ovf       out  sticky: a write was attempted while the FIFO was full
// ============================================================================
module handshake_src_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             sidle,
    output logic             sready,
    output logic [WIDTH-1:0] din,
    output logic             busy,
    output logic [15:0]      tx_count,
    output logic             ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               sready_q, sready_d;
    logic [WIDTH-1:0]   din_q, din_d;
    logic [15:0]        tx_count_q, tx_count_d;
    logic               ovf_q, ovf_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = in_valid && !fifo_full;

    // ------------------------------------------------------------------
    // FSM next state and launch datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sready_d   = 1'b0;      // sready only ever rises on the IDLE->SEND edge
        din_d      = din_q;     // din is held for the whole transfer
        tx_count_d = tx_count_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && sidle) begin
                    din_d    = mem_q[rd_ptr_q];
                    sready_d = 1'b1;
                    pop      = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // Synchronizer going busy confirms it captured the request.
                if (!sidle) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (sidle) begin
                    state_d    = IDLE;
                    tx_count_d = tx_count_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Sticky: a write offered while full is dropped but remembered.
        ovf_d    = ovf_q || (in_valid && fifo_full);
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sready_q   <= 1'b0;
            din_q      <= '0;
            tx_count_q <= 16'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sready_q   <= sready_d;
            din_q      <= din_d;
            tx_count_q <= tx_count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge sclk) begin
        mem_q <= mem_d;
    end

    assign in_ready = !fifo_full;
    assign sready   = sready_q;
    assign din      = din_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign tx_count = tx_count_q;
    assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_src_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_handshake_src_ctrl
//  Purpose  : Directed self-checking bench for handshake_src_ctrl.
//             Inputs are driven and outputs sampled on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_src_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             sclk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             sidle;
    logic             sready;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic [15:0]      tx_count;
    logic             ovf;

    int tests;
    int fails;

    handshake_src_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sidle    (sidle),
        .sready   (sready),
        .din      (din),
        .busy     (busy),
        .tx_count (tx_count),
        .ovf      (ovf)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic        iv;
        logic [7:0]  id;
        logic        si;
        logic        e_rdy;
        logic        e_srdy;
        logic [7:0]  e_din;
        logic        e_busy;
        logic [15:0] e_tx;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge sclk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sidle    = 1'b1;
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
    endtask

    // Called at the falling edge right after a launch edge (sready seen high).
    // Models the synchronizer: stays idle one more cycle, busy three cycles,
    // then idle again; din must stay put throughout.
    task automatic finish_xfer(input logic [7:0] exp);
        @(negedge sclk);
        chk("sready_pulse_len", {31'd0, sready}, 32'd0);
        chk("din_hold_send", {24'd0, din}, {24'd0, exp});
        sidle = 1'b0;
        repeat (3) begin
            @(negedge sclk);
            chk("din_hold_wait", {24'd0, din}, {24'd0, exp});
        end
        sidle = 1'b1;
        @(negedge sclk);
        chk("din_hold_done", {24'd0, din}, {24'd0, exp});
    endtask

    task automatic serve(input logic [7:0] exp);
        bit seen;
        seen  = 1'b0;
        sidle = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge sclk);
            if (sready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("launch_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            chk("din_at_launch", {24'd0, din}, {24'd0, exp});
            finish_xfer(exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sidle    = 1'b1;

        // Single word: write A5, synchronizer busy for 6 cycles.
        //            iv  data   si  rdy srdy din    busy tx     ovf
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 16'd0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 16'd0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1, 1'b0};

        // ---------------- reset values (during and after release) ----------
        repeat (2) @(negedge sclk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_sready",   {31'd0, sready},   32'd0);
        chk("rst_din",      {24'd0, din},      32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_tx",       {16'd0, tx_count}, 32'd0);
        chk("rst_ovf",      {31'd0, ovf},      32'd0);
        rst_n = 1'b1;
        @(negedge sclk);
        chk("rel_sready", {31'd0, sready}, 32'd0);
        chk("rel_busy",   {31'd0, busy},   32'd0);

        // ---------------- table: single word ----------------
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].iv;
            in_data  = tbl[i].id;
            sidle    = tbl[i].si;
            @(negedge sclk);
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_sready", i),   {31'd0, sready},   {31'd0, tbl[i].e_srdy});
            chk($sformatf("v%0d_din", i),      {24'd0, din},      {24'd0, tbl[i].e_din});
            chk($sformatf("v%0d_busy", i),     {31'd0, busy},     {31'd0, tbl[i].e_busy});
            chk($sformatf("v%0d_tx", i),       {16'd0, tx_count}, {16'd0, tbl[i].e_tx});
            chk($sformatf("v%0d_ovf", i),      {31'd0, ovf},      {31'd0, tbl[i].e_ovf});
        end

        // ---------------- burst of four ----------------
        do_reset();
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    chk("burst_in_ready", {31'd0, in_ready}, 32'd1);
                    in_valid = 1'b1;
                    in_data  = 8'(k);
                    @(negedge sclk);
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 1; k <= 4; k++) serve(8'(k));
            end
        join
        chk("burst_tx",  {16'd0, tx_count}, 32'd4);
        chk("burst_ovf", {31'd0, ovf},      32'd0);

        // ---------------- overflow ----------------
        do_reset();
        sidle = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                chk("ovf_full_in_ready", {31'd0, in_ready}, 32'd0);
                chk("ovf_before_drop",   {31'd0, ovf},      32'd0);
            end else begin
                chk("ovf_fill_in_ready", {31'd0, in_ready}, 32'd1);
            end
            in_valid = 1'b1;
            in_data  = 8'(8'h11 + k);
            @(negedge sclk);
        end
        in_valid = 1'b0;
        chk("ovf_set",    {31'd0, ovf},    32'd1);
        chk("ovf_sready", {31'd0, sready}, 32'd0);
        for (int k = 0; k < 4; k++) serve(8'(8'h11 + k));
        for (int c = 0; c < 10; c++) begin
            @(negedge sclk);
            chk("ovf_no_fifth", {31'd0, sready}, 32'd0);
        end
        chk("ovf_tx",     {16'd0, tx_count}, 32'd4);
        chk("ovf_sticky", {31'd0, ovf},      32'd1);
        chk("ovf_busy",   {31'd0, busy},     32'd0);

        // ---------------- blocked launch ----------------
        do_reset();
        sidle    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge sclk);
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sclk);
            chk("blk_sready", {31'd0, sready}, 32'd0);
            chk("blk_din",    {24'd0, din},    32'd0);
        end
        chk("blk_busy", {31'd0, busy}, 32'd1);
        sidle = 1'b1;
        @(negedge sclk);
        chk("blk_launch", {31'd0, sready}, 32'd1);
        chk("blk_din_launch", {24'd0, din}, 32'h3C);
        finish_xfer(8'h3C);
        chk("blk_tx", {16'd0, tx_count}, 32'd1);

        // ---------------- tx_count wrap ----------------
        do_reset();
        force dut.tx_count_q = 16'hFFFF;
        @(negedge sclk);
        release dut.tx_count_q;
        @(negedge sclk);
        chk("wrap_preset", {16'd0, tx_count}, 32'h0000FFFF);
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge sclk);
        in_valid = 1'b0;
        serve(8'h77);
        chk("wrap_tx", {16'd0, tx_count}, 32'd0);

        // ---------------- reset mid-WAIT ----------------
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h81;
        @(negedge sclk);
        in_data  = 8'h82;
        @(negedge sclk);
        chk("mw_launch", {31'd0, sready}, 32'd1);
        chk("mw_din",    {24'd0, din},    32'h81);
        in_data  = 8'h83;
        sidle    = 1'b0;
        @(negedge sclk);
        in_valid = 1'b0;
        @(negedge sclk);
        chk("mw_busy_wait", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mw_rst_sready",   {31'd0, sready},   32'd0);
        chk("mw_rst_din",      {24'd0, din},      32'd0);
        chk("mw_rst_busy",     {31'd0, busy},     32'd0);
        chk("mw_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mw_rst_tx",       {16'd0, tx_count}, 32'd0);
        chk("mw_rst_ovf",      {31'd0, ovf},      32'd0);
        @(negedge sclk);
        sidle = 1'b1;
        @(negedge sclk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge sclk);
            chk("mw_never_sent", {31'd0, sready}, 32'd0);
        end
        chk("mw_post_busy", {31'd0, busy},     32'd0);
        chk("mw_post_tx",   {16'd0, tx_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/handshake_src_ctrl.md
HANDSHAKE_SRC_CTRL -- requirements
Module: handshake_src_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of input FIFO entries (power of 2, at least 2).
REQ-003 The block SHALL have port sclk, input, 1 bit, the source-domain clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning an upstream word is offered.
REQ-006 The block SHALL have port in_data, input, WIDTH bits, the upstream word.
REQ-007 The block SHALL have port in_ready, output, 1 bit, equal to !fifo_full (combinational).
REQ-008 The block SHALL have port sidle, input, 1 bit, meaning the handshake synchronizer is idle (sreq=0 and sack=0).
REQ-009 The block SHALL have port sready, output, 1 bit, a registered one-cycle launch pulse to the synchronizer.
REQ-010 The block SHALL have port din, output, WIDTH bits, the registered word presented to the synchronizer.
REQ-011 The block SHALL have port busy, output, 1 bit, equal to (state != IDLE) || !fifo_empty.
REQ-012 The block SHALL have port tx_count, output, 16 bits, the number of completed transfers.
REQ-013 The block SHALL have port ovf, output, 1 bit, a sticky flag meaning a write was attempted while the FIFO was full.

Function
REQ-014 Accepting input SHALL mean that the FIFO write fires when in_valid && in_ready at a rising edge of sclk; the word is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-015 In-order storage SHALL hold: the FIFO keeps words in arrival order, with an occupancy counter of 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-016 A simultaneous push and pop in the same cycle SHALL leave count unchanged, and both pointers SHALL advance.
REQ-017 An in_valid while full SHALL drop the word, leave the FIFO unchanged, and set ovf=1 on the next edge; ovf clears only on reset.
REQ-018 The FSM SHALL have exactly three states: IDLE, SEND and WAIT.
REQ-019 IDLE with !empty && sidle SHALL, on the next edge: set din<=fifo head, sready<=1, pop the FIFO, and set state<=SEND.
REQ-020 IDLE otherwise SHALL hold, with sready=0; no launch occurs while sidle=0, even if data is pending.
REQ-021 SEND SHALL set sready<=0 unconditionally on the next edge, so sready is high for exactly 1 cycle; it moves to WAIT when sidle==0 and otherwise stays in SEND.
REQ-022 WAIT SHALL stay in WAIT while sidle==0; on sidle==1 it SHALL set state<=IDLE and tx_count<=tx_count+1, wrapping 0xFFFF->0x0000.
REQ-023 din SHALL be stable from the edge that raises sready until the edge on which the FSM leaves WAIT; din changes only in IDLE at launch.
REQ-024 At most one transfer SHALL be outstanding; sready is never asserted outside the IDLE->SEND transition.
REQ-025 Minimum per-word latency SHALL be: a word written into an empty FIFO with the FSM in IDLE and sidle=1 produces sready=1 two edges after the write edge (write edge, then launch edge).
REQ-026 Back-to-back operation SHALL proceed as follows: after WAIT->IDLE, the next launch occurs on the following edge if !empty && sidle.

Reset
REQ-027 While rst_n=0 the block SHALL hold: state=IDLE, sready=0, din=0, tx_count=0, ovf=0, FIFO pointers and count =0, so in_ready=1 and busy=0.
REQ-028 Asserting rst_n mid-transfer SHALL abort immediately, discarding FIFO contents; after release the block waits for sidle=1 before any launch.
REQ-029 Reset release SHALL be treated synchronously to sclk by the integrating level; no output SHALL change on the release edge itself.

Verification
REQ-030 Single word: write 0xA5 with sidle=1 and model sidle to drop 1 cycle after sready, held low 6 cycles -> sready is a 1-cycle pulse, din=0xA5 until return to IDLE, tx_count=1.
REQ-031 Burst: write 0x01,0x02,0x03,0x04 on consecutive cycles (DEPTH=4) -> in_ready stays 1, din sequence is 01,02,03,04, tx_count=4, ovf=0.
REQ-032 Overflow: hold sidle=0 and write 5 words -> 4th write sets full, in_ready=0; the 5th is dropped, ovf=1; after sidle rises, exactly 4 words are delivered in order.
REQ-033 Blocked launch: FIFO non-empty with sidle=0 for 10 cycles -> sready stays 0, state stays IDLE; when sidle=1, the launch occurs on the next edge.
REQ-034 Wrap: preset 0xFFFF completions (force or long run), one more transfer -> tx_count=0x0000.
REQ-035 Reset mid-WAIT: assert rst_n=0 while in WAIT holding 2 queued words -> all outputs at reset values, and the queued words are never sent.
